// File: rtl/cpu_memory_sb.sv
// cpu_memory_sb: pipeline memory stage with a posted-store FIFO and
// byte-masked bus writes (no read-modify-write).
// Ports: i_clock, i_reset_n (async, active low);
//   bus side: o_bus_rw/request/flush/address/wdata/wmask, i_bus_ready, i_bus_rdata;
//   execute side: i_tag, i_inst_rd, i_rd, i_mem_read/write/flush/width/signed/address;
//   writeback side: o_tag, o_inst_rd, o_rd; status: o_stall, o_sb_count;
//   o_fault/o_fault_address (misalignment trap).
// Build option: define CPU_MEMORY_MISALIGN_TRAP_EN to trap misaligned
// accesses; otherwise they are aligned down and the fault outputs are tied 0.
module cpu_memory_sb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SB_DEPTH   = 4,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                           i_clock,
   input  logic                           i_reset_n,
   output logic                           o_bus_rw,
   output logic                           o_bus_request,
   output logic                           o_bus_flush,
   input  logic                           i_bus_ready,
   output logic [ADDR_WIDTH-1:0]          o_bus_address,
   input  logic [DATA_WIDTH-1:0]          i_bus_rdata,
   output logic [DATA_WIDTH-1:0]          o_bus_wdata,
   output logic [DATA_WIDTH/8-1:0]        o_bus_wmask,
   input  logic [TAG_WIDTH-1:0]           i_tag,
   input  logic [4:0]                     i_inst_rd,
   input  logic [DATA_WIDTH-1:0]          i_rd,
   input  logic                           i_mem_read,
   input  logic                           i_mem_write,
   input  logic                           i_mem_flush,
   input  logic [3:0]                     i_mem_width,
   input  logic                           i_mem_signed,
   input  logic [ADDR_WIDTH-1:0]          i_mem_address,
   output logic [TAG_WIDTH-1:0]           o_tag,
   output logic [4:0]                     o_inst_rd,
   output logic [DATA_WIDTH-1:0]          o_rd,
   output logic                           o_stall,
   output logic [$clog2(SB_DEPTH):0]      o_sb_count,
   output logic                           o_fault,
   output logic [ADDR_WIDTH-1:0]          o_fault_address
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int LW = $clog2(NB);
   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_BUSY = 1'b1;

   logic [1:0]            state;
   logic [0:0]            wstate;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   logic [ADDR_WIDTH-1:0] sb_addr [SB_DEPTH];
   logic [DATA_WIDTH-1:0] sb_data [SB_DEPTH];
   logic [NB-1:0]         sb_mask [SB_DEPTH];

   logic                  new_op;
   logic                  fault;
   logic                  retire;
   logic                  push;
   logic                  pop;
   logic                  start_rd;
   logic                  start_fl;
   logic                  drain_go;
   logic                  sb_full;
   logic                  sb_empty;
   logic [3:0]            width_m1;
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [LW-1:0]         lane;
   logic [NB-1:0]         st_mask;
   logic [DATA_WIDTH-1:0] st_data;
   logic [DATA_WIDTH-1:0] rsh;
   logic [DATA_WIDTH-1:0] keep;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  sbit;

   assign new_op   = (i_tag != o_tag);
   assign width_m1 = i_mem_width - 4'd1;

   // Align down to the access width, then to the bus word.
   assign eff_addr = i_mem_address & ~ADDR_WIDTH'(width_m1);
   assign bus_addr = eff_addr & ~ADDR_WIDTH'(NB - 1);
   assign lane     = eff_addr[LW-1:0];

   // Wider-than-bus widths saturate to a full-word mask.
   assign st_mask = NB'((16'd1 << i_mem_width) - 16'd1) << lane;
   assign st_data = i_rd << {lane, 3'b000};

   assign rsh = i_bus_rdata >> {lane, 3'b000};

   always_comb begin
      keep = '1;
      sbit = 1'b0;
      unique case (1'b1)
         (i_mem_width == 4'd1): begin
            keep = DATA_WIDTH'(8'hFF);
            sbit = rsh[7];
         end
         (i_mem_width == 4'd2): begin
            keep = DATA_WIDTH'(16'hFFFF);
            sbit = rsh[15];
         end
         (i_mem_width == 4'd4): begin
            keep = DATA_WIDTH'(32'hFFFF_FFFF);
            sbit = rsh[31];
         end
         default: ;
      endcase
      ld_data = (rsh & keep)
              | ({DATA_WIDTH{i_mem_signed & sbit}} & ~keep);
   end

   assign sb_full  = (o_sb_count == CW'(SB_DEPTH));
   assign sb_empty = (o_sb_count == '0) && (wstate == W_IDLE);
   assign pop      = (wstate == W_BUSY) && i_bus_ready;
   assign drain_go = (wstate == W_IDLE) && (o_sb_count != '0)
                   && (state == S_IDLE);

   always_comb begin
      retire   = 1'b0;
      push     = 1'b0;
      start_rd = 1'b0;
      start_fl = 1'b0;
      if (new_op) begin
         if (state == S_IDLE) begin
            unique case (1'b1)
               fault: retire = 1'b1;
               i_mem_write: begin
                  // Full means "wait", even if a pop lands this cycle.
                  push   = !sb_full;
                  retire = !sb_full;
               end
               i_mem_read:  start_rd = sb_empty;
               i_mem_flush: start_fl = sb_empty;
               default:     retire   = 1'b1;
            endcase
         end else begin
            retire = i_bus_ready;
         end
      end
   end

   assign o_stall = new_op && !retire;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= S_IDLE;
         wstate        <= W_IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         o_sb_count    <= '0;
         o_tag         <= '0;
         o_inst_rd     <= '0;
         o_rd          <= '0;
         o_bus_request <= 1'b0;
         o_bus_rw      <= 1'b0;
         o_bus_flush   <= 1'b0;
         o_bus_address <= '0;
         o_bus_wdata   <= '0;
         o_bus_wmask   <= '0;
      end else begin
         if (retire) begin
            o_tag <= i_tag;
            if (fault) begin
               o_inst_rd <= '0;
               o_rd      <= '0;
            end else begin
               o_inst_rd <= i_inst_rd;
               o_rd      <= (state == S_READ) ? ld_data : i_rd;
            end
         end

         unique case (state)
            S_IDLE: begin
               if (start_rd)
                  state <= S_READ;
               else if (start_fl)
                  state <= S_FLUSH;
            end
            default: begin
               if (i_bus_ready)
                  state <= S_IDLE;
            end
         endcase

         if (drain_go)
            wstate <= W_BUSY;
         else if (pop)
            wstate <= W_IDLE;

         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         o_sb_count <= o_sb_count + CW'(push) - CW'(pop);

         // Single registered requester; the head entry stays in the
         // buffer until its write completes.
         if (drain_go) begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b1;
            o_bus_flush   <= 1'b0;
            o_bus_address <= sb_addr[rd_ptr];
            o_bus_wdata   <= sb_data[rd_ptr];
            o_bus_wmask   <= sb_mask[rd_ptr];
         end else if (start_rd || start_fl) begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b0;
            o_bus_flush   <= start_fl;
            o_bus_address <= bus_addr;
            o_bus_wmask   <= '0;
         end else if (o_bus_request && i_bus_ready) begin
            o_bus_request <= 1'b0;
            o_bus_flush   <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (push) begin
         sb_addr[wr_ptr] <= bus_addr;
         sb_data[wr_ptr] <= st_data;
         sb_mask[wr_ptr] <= st_mask;
      end
   end

`ifdef CPU_MEMORY_MISALIGN_TRAP_EN
   logic misaligned;

   assign misaligned =
      ((i_mem_address & ADDR_WIDTH'(width_m1)) != '0)
      || ((DATA_WIDTH == 32) && (i_mem_width == 4'd8));

   assign fault = new_op && (state == S_IDLE) && misaligned
                && (i_mem_read || i_mem_write || i_mem_flush);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_fault         <= 1'b0;
         o_fault_address <= '0;
      end else begin
         o_fault <= fault;
         if (fault)
            o_fault_address <= i_mem_address;
      end
   end
`else
   assign fault           = 1'b0;
   assign o_fault         = 1'b0;
   assign o_fault_address = '0;
`endif

endmodule

// File: tb/tb_cpu_memory_sb.sv
// tb_cpu_memory_sb: scoreboard bench for cpu_memory_sb with a
// delayed-ready bus responder and a byte-level memory model.
`timescale 1ns/1ps
module tb_cpu_memory_sb;

   localparam int K_NONE = 0;
   localparam int K_LD   = 1;
   localparam int K_ST   = 2;
   localparam int K_FL   = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bus_rw;
   logic        bus_request;
   logic        bus_flush;
   logic        bus_ready;
   logic [31:0] bus_address;
   logic [31:0] bus_rdata;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wmask;
   logic [3:0]  i_tag;
   logic [4:0]  i_inst_rd;
   logic [31:0] i_rd;
   logic        mem_read;
   logic        mem_write;
   logic        mem_flush;
   logic [3:0]  mem_width;
   logic        mem_signed;
   logic [31:0] mem_address;
   logic [3:0]  o_tag;
   logic [4:0]  o_inst_rd;
   logic [31:0] o_rd;
   logic        stall;
   logic [2:0]  sb_count;
   logic        fault;
   logic [31:0] fault_address;

   cpu_memory_sb dut (
      .i_clock         (clk),
      .i_reset_n       (rst_n),
      .o_bus_rw        (bus_rw),
      .o_bus_request   (bus_request),
      .o_bus_flush     (bus_flush),
      .i_bus_ready     (bus_ready),
      .o_bus_address   (bus_address),
      .i_bus_rdata     (bus_rdata),
      .o_bus_wdata     (bus_wdata),
      .o_bus_wmask     (bus_wmask),
      .i_tag           (i_tag),
      .i_inst_rd       (i_inst_rd),
      .i_rd            (i_rd),
      .i_mem_read      (mem_read),
      .i_mem_write     (mem_write),
      .i_mem_flush     (mem_flush),
      .i_mem_width     (mem_width),
      .i_mem_signed    (mem_signed),
      .i_mem_address   (mem_address),
      .o_tag           (o_tag),
      .o_inst_rd       (o_inst_rd),
      .o_rd            (o_rd),
      .o_stall         (stall),
      .o_sb_count      (sb_count),
      .o_fault         (fault),
      .o_fault_address (fault_address)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } bus_t;

   bus_t        exp_bus[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          ready_delay = 0;
   int          txn_cnt = 0;
   int          req_rises = 0;
   int          cnt_peak = 0;
   logic [3:0]  tag = 4'h0;
   logic [7:0]  shadow [logic [31:0]];
   logic [7:0]  busmem [logic [31:0]];

   task automatic chk(input string t, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", t, obs, exp);
      end
   endtask

   function automatic logic [7:0] sh_rd(input logic [31:0] a);
      return shadow.exists(a) ? shadow[a] : 8'h00;
   endfunction

   function automatic logic [7:0] bm_rd(input logic [31:0] a);
      return busmem.exists(a) ? busmem[a] : 8'h00;
   endfunction

   // Bus responder: ready after ready_delay cycles of request.
   initial begin : responder
      int   wcnt;
      bus_t e;
      logic [1:0] k;
      wcnt = 0;
      bus_ready = 1'b0;
      bus_rdata = '0;
      forever begin
         @(negedge clk);
         bus_ready = 1'b0;
         if (!rst_n || !bus_request) begin
            wcnt = 0;
         end else if (wcnt < ready_delay) begin
            wcnt++;
         end else begin
            wcnt = 0;
            bus_ready = 1'b1;
            txn_cnt++;
            k = bus_flush ? 2'd2 : (bus_rw ? 2'd1 : 2'd0);
            chk("bus_expected", 64'(exp_bus.size() != 0), 64'd1);
            if (exp_bus.size() != 0) begin
               e = exp_bus.pop_front();
               chk("bus_kind", 64'(k), 64'(e.kind));
               chk("bus_addr", 64'(bus_address), 64'(e.addr));
               if (e.kind == 2'd1) begin
                  chk("bus_wdata", 64'(bus_wdata), 64'(e.data));
                  chk("bus_wmask", 64'(bus_wmask), 64'(e.mask));
                  for (int i = 0; i < 4; i++)
                     if (bus_wmask[i])
                        busmem[bus_address + 32'(i)] = bus_wdata[8*i +: 8];
               end else if (e.kind == 2'd0) begin
                  bus_rdata = {bm_rd(bus_address + 32'd3),
                               bm_rd(bus_address + 32'd2),
                               bm_rd(bus_address + 32'd1),
                               bm_rd(bus_address)};
               end
            end
         end
      end
   end

   // Stability of held request fields, request count, occupancy peak.
   initial begin : monitor
      logic        prev_req;
      logic [31:0] prev_addr;
      logic [31:0] prev_wd;
      prev_req = 1'b0;
      prev_addr = '0;
      prev_wd = '0;
      forever begin
         @(negedge clk);
         if (bus_request && !prev_req)
            req_rises++;
         if (bus_request && prev_req) begin
            chk("addr_stable", 64'(bus_address), 64'(prev_addr));
            chk("wdata_stable", 64'(bus_wdata), 64'(prev_wd));
         end
         if (int'(sb_count) > cnt_peak)
            cnt_peak = int'(sb_count);
         prev_req = bus_request;
         prev_addr = bus_address;
         prev_wd = bus_wdata;
      end
   end

   task automatic issue(input int kind, input logic [31:0] addr,
                        input logic [3:0] w, input logic sgn,
                        input logic [31:0] d, input logic [4:0] rd,
                        output int lat, output int s0, output int lo);
      logic        trap;
      logic [31:0] ea;
      logic [31:0] wa;
      logic [31:0] v;
      logic [31:0] exp_rd;
      logic [4:0]  exp_ird;
      int          lane;
      bus_t        e;
      trap = 1'b0;
`ifdef CPU_MEMORY_MISALIGN_TRAP_EN
      trap = (kind != K_NONE) && ((addr % 32'(w)) != 0);
`endif
      ea = addr & ~(32'(w) - 32'd1);
      wa = ea & ~32'd3;
      lane = int'(ea[1:0]);
      exp_rd = d;
      exp_ird = rd;
      if (trap) begin
         exp_rd = '0;
         exp_ird = '0;
      end else if (kind == K_ST) begin
         e.kind = 2'd1;
         e.addr = wa;
         e.data = d << (8 * lane);
         e.mask = 4'(((1 << int'(w)) - 1) << lane);
         exp_bus.push_back(e);
         for (int b = 0; b < int'(w); b++)
            shadow[ea + 32'(b)] = d[8*b +: 8];
      end else if (kind == K_LD) begin
         e.kind = 2'd0;
         e.addr = wa;
         e.data = '0;
         e.mask = '0;
         exp_bus.push_back(e);
         v = '0;
         for (int b = 0; b < int'(w); b++)
            v = v | (32'(sh_rd(ea + 32'(b))) << (8 * b));
         if (sgn && w < 4'd4 && v[8*int'(w)-1])
            v = v | ~((32'd1 << (8 * int'(w))) - 32'd1);
         exp_rd = v;
      end else if (kind == K_FL) begin
         e.kind = 2'd2;
         e.addr = wa;
         e.data = '0;
         e.mask = '0;
         exp_bus.push_back(e);
      end
      tag = (tag == 4'hF) ? 4'h1 : tag + 4'h1;
      i_tag = tag;
      i_inst_rd = rd;
      i_rd = d;
      mem_read = (kind == K_LD);
      mem_write = (kind == K_ST);
      mem_flush = (kind == K_FL);
      mem_width = w;
      mem_signed = sgn;
      mem_address = addr;
      #1 s0 = int'(stall);
      lat = 0;
      lo = 0;
      forever begin
         @(negedge clk);
         lat++;
         if (o_tag == tag) break;
         if (!stall) lo++;
         if (lat > 400) break;
      end
      chk("retire_seen", 64'(o_tag), 64'(tag));
      chk("ret_inst_rd", 64'(o_inst_rd), 64'(exp_ird));
      chk("ret_rd", 64'(o_rd), 64'(exp_rd));
      mem_read = 1'b0;
      mem_write = 1'b0;
      mem_flush = 1'b0;
   endtask

   task automatic wait_idle(input string t);
      int n;
      n = 0;
      while ((exp_bus.size() != 0 || bus_request || sb_count != 0)
             && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(t, 64'(n < 500), 64'd1);
      @(negedge clk);
   endtask

   task automatic wait_req(input string t);
      int n;
      n = 0;
      while (!bus_request && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk(t, 64'(bus_request), 64'd1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int lat;
      int s0;
      int lo;
      int r0;
      int q0;
      int lats[5];
      i_tag = '0;
      i_inst_rd = '0;
      i_rd = '0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      mem_flush = 1'b0;
      mem_width = 4'd4;
      mem_signed = 1'b0;
      mem_address = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", 64'(bus_request), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_count", 64'(sb_count), 64'd0);
      chk("rst_tag", 64'(o_tag), 64'd0);
      chk("rst_rd", 64'(o_rd), 64'd0);
      chk("rst_wmask", 64'(bus_wmask), 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Byte store into the top lane.
      ready_delay = 2;
      issue(K_ST, 32'h1003, 4'd1, 1'b0, 32'hAB, 5'd3, lat, s0, lo);
      chk("st_nostall", 64'(s0), 64'd0);
      chk("st_lat", 64'(lat), 64'd1);
      wait_req("st_req_seen");
      chk("st_addr", 64'(bus_address), 64'h1000);
      chk("st_wmask", 64'(bus_wmask), 64'h8);
      chk("st_wdata", 64'(bus_wdata), 64'hAB00_0000);
      chk("st_rw", 64'(bus_rw), 64'd1);
      wait_idle("t1_drain");

      // Five back-to-back stores against a slow bus.
      ready_delay = 10;
      cnt_peak = 0;
      for (int i = 0; i < 5; i++) begin
         issue(K_ST, 32'h100 + 32'(4 * i), 4'd4, 1'b0,
               32'h1111_1111 * 32'(i + 1), 5'(i + 1), lat, s0, lo);
         lats[i] = lat;
         if (i == 4)
            chk("st5_stall_now", 64'(s0), 64'd1);
      end
      for (int i = 0; i < 4; i++)
         chk("st_burst_lat", 64'(lats[i]), 64'd1);
      chk("st5_waited", 64'(lats[4] > 5), 64'd1);
      chk("sb_peak", 64'(cnt_peak), 64'd4);
      wait_idle("t2_drain");

      // Load after store waits for the drain.
      ready_delay = 1;
      issue(K_ST, 32'h2001, 4'd1, 1'b0, 32'h80, 5'd4, lat, s0, lo);
      issue(K_LD, 32'h2001, 4'd1, 1'b1, 32'h0, 5'd5, lat, s0, lo);
      chk("ld_sx_val", 64'(o_rd), 64'hFFFF_FF80);
      chk("ld_waited", 64'(lat > 2), 64'd1);
      wait_idle("t3_drain");
      ready_delay = 0;
      issue(K_LD, 32'h2001, 4'd1, 1'b0, 32'h0, 5'd6, lat, s0, lo);
      chk("ld_min_lat", 64'(lat), 64'd2);
      issue(K_LD, 32'h2000, 4'd2, 1'b1, 32'h0, 5'd7, lat, s0, lo);
      wait_idle("t3_idle");

      // Flush behind two queued stores.
      ready_delay = 3;
      issue(K_ST, 32'h2100, 4'd4, 1'b0, 32'hDEAD_BEEF, 5'd8, lat, s0, lo);
      issue(K_ST, 32'h2106, 4'd2, 1'b0, 32'h5555, 5'd9, lat, s0, lo);
      issue(K_FL, 32'h2100, 4'd4, 1'b0, 32'h77, 5'd10, lat, s0, lo);
      chk("fl_stall_start", 64'(s0), 64'd1);
      chk("fl_stall_hold", 64'(lo), 64'd0);
      wait_idle("t4_drain");

      // Misaligned halfword load.
      ready_delay = 0;
      issue(K_ST, 32'h3000, 4'd4, 1'b0, 32'h1234_ABCD, 5'd11, lat, s0, lo);
      wait_idle("t5_prep");
      r0 = req_rises;
      issue(K_LD, 32'h3001, 4'd2, 1'b0, 32'h0, 5'd12, lat, s0, lo);
`ifdef CPU_MEMORY_MISALIGN_TRAP_EN
      chk("mis_lat", 64'(lat), 64'd1);
      chk("mis_fault", 64'(fault), 64'd1);
      chk("mis_faddr", 64'(fault_address), 64'h3001);
      @(negedge clk);
      chk("mis_pulse", 64'(fault), 64'd0);
      chk("mis_no_bus", 64'(req_rises - r0), 64'd0);
`else
      chk("mis_val", 64'(o_rd), 64'hABCD);
      chk("mis_fault", 64'(fault), 64'd0);
      chk("mis_one_read", 64'(req_rises - r0), 64'd1);
`endif
      wait_idle("t5_idle");

      // Reset in the middle of a drain.
      ready_delay = 10;
      for (int i = 0; i < 3; i++)
         issue(K_ST, 32'h4000 + 32'(4 * i), 4'd4, 1'b0,
               32'hA0 + 32'(i), 5'(13 + i), lat, s0, lo);
      wait_req("rst_drain_req");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      i_tag = '0;
      #1;
      chk("rst_req_drop", 64'(bus_request), 64'd0);
      chk("rst_count_clr", 64'(sb_count), 64'd0);
      exp_bus.delete();
      r0 = txn_cnt;
      q0 = req_rises;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("post_rst_count", 64'(sb_count), 64'd0);
      chk("post_rst_reqs", 64'(req_rises - q0), 64'd0);
      chk("post_rst_txn", 64'(txn_cnt - r0), 64'd0);

      // Operation resumes after reset.
      ready_delay = 0;
      issue(K_NONE, 32'h0, 4'd4, 1'b0, 32'h5A5A_5A5A, 5'd20, lat, s0, lo);
      chk("pass_lat", 64'(lat), 64'd1);
      issue(K_ST, 32'h5000, 4'd4, 1'b0, 32'hCAFE_F00D, 5'd21, lat, s0, lo);
      issue(K_LD, 32'h5002, 4'd2, 1'b0, 32'h0, 5'd22, lat, s0, lo);
      chk("ld_hi_half", 64'(o_rd), 64'hCAFE);
      wait_idle("t7_idle");

      chk("bus_q_empty", 64'(exp_bus.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
